// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings: the
// instruction-cache read port, the branch redirect and the IF/ID buffer side.
//
// Handshake semantics:
//   Cache side: icache_read is a request that stays high, with icache_address
//   stable, until the cycle in which icache_resp = 1; icache_rdata is sampled
//   only in that cycle.
//   Buffer side: valid_out is the "valid" and ~stall is the "ready". A
//   transfer happens exactly on an edge where valid_out = 1, stall = 0 and
//   br_taken = 0. A redirect overrides the transfer and squashes the word.
interface fetch_stage_if;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        icache_resp;
  logic [15:0] icache_rdata;
  logic        icache_read;
  logic [15:0] icache_address;
  logic [15:0] instruction_out;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2_out;
  logic        valid_out;
  logic [1:0]  state_dbg;

  modport master (
    input  stall, br_taken, br_target, icache_resp, icache_rdata,
    output icache_read, icache_address, instruction_out, pc_out,
           pc_plus2_out, valid_out, state_dbg
  );

  modport slave (
    output stall, br_taken, br_target, icache_resp, icache_rdata,
    input  icache_read, icache_address, instruction_out, pc_out,
           pc_plus2_out, valid_out, state_dbg
  );
endinterface

// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage. Owns the PC, runs a blocking read handshake
// with the instruction cache, and presents instruction / PC / PC+2 to the
// IF/ID buffer. A branch redirect squashes any wrong-path fetch; a request
// already issued to the cache is allowed to complete (FLUSH) so its address
// never changes while icache_read is high.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INSN = 16'h0000
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic [15:0] req_addr, req_addr_nx;
  logic [15:0] ir, ir_nx;
  logic [15:0] pc_q, pc_q_nx;
  logic [15:0] pc2_q, pc2_q_nx;

  // Redirect targets are halfword aligned; bit 0 is dropped.
  logic [15:0] target;
  logic [15:0] req_plus2;
  assign target    = {bus.br_target[15:1], 1'b0};
  assign req_plus2 = req_addr + 16'd2;

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      ir       <= NOP_INSN;
      pc_q     <= RESET_PC;
      pc2_q    <= RESET_PC + 16'd2;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      req_addr <= req_addr_nx;
      ir       <= ir_nx;
      pc_q     <= pc_q_nx;
      pc2_q    <= pc2_q_nx;
    end
  end

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    req_addr_nx = req_addr;
    ir_nx       = ir;
    pc_q_nx     = pc_q;
    pc2_q_nx    = pc2_q;
    case (state)
      IDLE: begin
        req_addr_nx = pc;
        state_nx    = FETCH;
      end
      FETCH: begin
        if (bus.icache_resp && !bus.br_taken) begin
          ir_nx    = bus.icache_rdata;
          pc_q_nx  = req_addr;
          pc2_q_nx = req_plus2;
          pc_nx    = req_plus2;
          state_nx = HOLD;
        end else if (bus.icache_resp && bus.br_taken) begin
          // Request finished this cycle, so the new one can start at once.
          pc_nx       = target;
          req_addr_nx = target;
        end else if (bus.br_taken) begin
          // Address must stay stable; drain the wrong-path read in FLUSH.
          pc_nx    = target;
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.br_taken) begin
          pc_nx = target;
        end
        if (bus.icache_resp) begin
          req_addr_nx = bus.br_taken ? target : pc;
          state_nx    = FETCH;
        end
      end
      HOLD: begin
        if (bus.br_taken) begin
          pc_nx       = target;
          req_addr_nx = target;
          state_nx    = FETCH;
        end else if (!bus.stall) begin
          req_addr_nx = pc;
          state_nx    = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; invalid cycles show a NOP.
  always_comb begin
    bus.icache_read     = (state == FETCH) || (state == FLUSH);
    bus.valid_out       = (state == HOLD);
    bus.icache_address  = req_addr;
    bus.instruction_out = (state == HOLD) ? ir : NOP_INSN;
    bus.pc_out          = pc_q;
    bus.pc_plus2_out    = pc2_q;
    bus.state_dbg       = state;
  end

endmodule
